// File: rtl/difftest_commit_source_pkg.sv
// Shared difftest definitions: commit-source run state and default datapath width.
package difftest_commit_source_pkg;

   localparam int DIFFTEST_DATA_W = 64;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } run_state_e;

   function automatic logic rising_edge(input logic cur, input logic prev);
      return cur && !prev;
   endfunction

endpackage

// File: rtl/commit_fifo.sv
// First-word-fall-through FIFO; the head entry is visible combinationally on rd_data.
module commit_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // The extra MSB on each pointer tells full apart from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/difftest_commit_source.sv
// Queues retiring instructions and presents them to the difftest sink; halts after an ebreak commit.
module difftest_commit_source
   import difftest_commit_source_pkg::*;
#(
   parameter int DATA_W = DIFFTEST_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [DATA_W-1:0] wb_pc,
   input  logic              wb_ebreak,
   input  logic              timer_int,
   input  logic              sink_ready,
   output logic              wb_ready,
   output logic              inst_commit,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] debug_pc,
   output logic              cpu_timer_int,
   output logic              cpu_ebreak_sign,
   output logic              overflow,
   output logic [DATA_W-1:0] commit_cnt
);

   localparam int ENTRY_W = DATA_W + 1;

   run_state_e         state;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               head_ebreak;
   logic               timer_int_p1;
   logic [ENTRY_W-1:0] head;

   assign wb_ready    = !full && (state == ST_RUN);
   assign inst_commit = !empty && (state == ST_RUN);
   assign push        = wb_valid && wb_ready;
   assign pop         = inst_commit && sink_ready;
   assign pc          = head[DATA_W:1];
   assign head_ebreak = head[0];

   commit_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_data ({wb_pc, wb_ebreak}),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= ST_RUN;
         overflow        <= 1'b0;
         debug_pc        <= '0;
         commit_cnt      <= '0;
         cpu_ebreak_sign <= 1'b0;
         cpu_timer_int   <= 1'b0;
         timer_int_p1    <= 1'b0;
      end else begin
         // A retire refused while running is lost; once halted the core is expected to stop retiring.
         if ((state == ST_RUN) && wb_valid && !wb_ready) overflow <= 1'b1;
         if (pop) begin
            debug_pc   <= pc;
            commit_cnt <= commit_cnt + DATA_W'(1);
            if (head_ebreak) state <= ST_HALTED;
         end
         cpu_ebreak_sign <= pop && head_ebreak;
         timer_int_p1    <= timer_int;
         cpu_timer_int   <= (state == ST_RUN) && rising_edge(timer_int, timer_int_p1);
      end
   end

endmodule

// File: doc/difftest_commit_source.md
DIFFTEST_COMMIT_SOURCE -- requirements
Module: difftest_commit_source

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the PC and counter datapath.
REQ-002 SHALL have parameter DEPTH, default 4, commit FIFO depth; power of two, at least 2.
REQ-003 SHALL have port clock, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wb_valid, input, 1, a writeback-stage instruction retires this cycle.
REQ-006 SHALL have port wb_pc, input, DATA_W, PC of the retiring instruction.
REQ-007 SHALL have port wb_ebreak, input, 1, the retiring instruction is ebreak.
REQ-008 SHALL have port timer_int, input, 1, level timer-interrupt-taken indication from the CSR unit.
REQ-009 SHALL have port sink_ready, input, 1, the difftest sink accepts the presented commit.
REQ-010 SHALL have port wb_ready, output, 1, FIFO can accept a retire.
REQ-011 SHALL have port inst_commit, output, 1, valid commit presented to the sink.
REQ-012 SHALL have port pc, output, DATA_W, PC of the presented commit.
REQ-013 SHALL have port debug_pc, output, DATA_W, PC of the last accepted commit.
REQ-014 SHALL have port cpu_timer_int, output, 1, one-cycle interrupt-taken pulse.
REQ-015 SHALL have port cpu_ebreak_sign, output, 1, one-cycle halt pulse.
REQ-016 SHALL have port overflow, output, 1, sticky flag: a retire was dropped.
REQ-017 SHALL have port commit_cnt, output, DATA_W, count of accepted commits.

Function
REQ-018 SHALL store {wb_pc, wb_ebreak} in the FIFO on push, where push = wb_valid && wb_ready.
REQ-019 SHALL drive wb_ready = !full && state==RUN.
REQ-020 SHALL drive inst_commit = !empty && state==RUN, with pc taken combinationally from the FIFO head.
REQ-021 SHALL pop the head on pop = inst_commit && sink_ready.
REQ-022 SHALL hold inst_commit and pc stable while sink_ready is low.
REQ-023 SHALL give push-to-visible latency of one cycle: an entry pushed in cycle N appears on inst_commit in cycle N+1 at the earliest.
REQ-024 SHALL allow push and pop in the same cycle when neither full nor empty; occupancy is then unchanged.
REQ-025 SHALL, when full, allow no push; wb_valid with wb_ready low in state RUN sets overflow, and the retire is dropped.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-027 SHALL register debug_pc <= head pc on each pop.
REQ-028 SHALL increment commit_cnt by 1 on each pop, wrapping at 2^DATA_W.
REQ-029 SHALL implement the state machine RUN -> HALTED when a popped entry has its ebreak flag; HALTED is terminal until reset.
REQ-030 SHALL assert cpu_ebreak_sign for exactly the cycle after the ebreak pop.
REQ-031 SHALL, in state HALTED, drive inst_commit=0 and wb_ready=0; wb_valid is ignored and does not set overflow.
REQ-032 SHALL assert cpu_timer_int for one cycle in the cycle after a 0->1 edge of timer_int, in state RUN only.
REQ-033 SHALL produce one pulse per edge when timer_int is held high.
REQ-034 SHALL let a timer edge and a commit pop in the same cycle each produce their own outputs independently.

Reset
REQ-035 SHALL, on reset low, immediately clear pointers, overflow, debug_pc, commit_cnt, cpu_timer_int, cpu_ebreak_sign and the timer edge register, and set state RUN.
REQ-036 SHALL derive inst_commit=0 and wb_ready=1 combinationally from reset state.
REQ-037 SHALL discard all in-flight FIFO entries on reset mid-operation; FIFO data storage is not reset.

Structure
REQ-038 SHALL place the state encoding (RUN, HALTED) and the default DATA_W in the shared difftest package.
REQ-039 SHALL instantiate one sub-module commit_fifo (parameterised width/depth, first-word-fall-through).

Verification
REQ-040 SHALL cover: 3 retires pc=0x80000000,0x80000004,0x80000008 with sink_ready=1 -> three inst_commit cycles in order, commit_cnt=3, debug_pc=0x80000008.
REQ-041 SHALL cover: sink_ready=0 with 5 retires at DEPTH=4 -> wb_ready low after 4 pushes, 5th dropped, overflow=1; then release -> exactly 4 commits.
REQ-042 SHALL cover: simultaneous push/pop with 2 entries for 10 cycles -> occupancy stays 2, no overflow.
REQ-043 SHALL cover: retire pc=0x80000010 with wb_ebreak=1, then further retires -> cpu_ebreak_sign one cycle after its pop, no later inst_commit, wb_ready=0.
REQ-044 SHALL cover: timer_int held high 5 cycles -> exactly one cpu_timer_int pulse one cycle after the rising edge.
REQ-045 SHALL cover: reset low with 3 entries queued -> outputs cleared asynchronously, commit_cnt=0, no commit after release.
